// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO controller: address map, FSM states,
// access targets and the address decoder.
package mmio_pkg;

  localparam logic [15:0] MEM_TOP    = 16'hBFFF;
  localparam logic [15:0] LED_ADDR   = 16'hC000;
  localparam logic [15:0] SW_ADDR    = 16'hC001;
  localparam logic [15:0] SPART_BASE = 16'hC004;

  typedef enum logic [1:0] {IDLE, WAIT, STROBE, DONE} state_e;

  typedef enum logic [2:0] {T_MEM, T_LED, T_SW, T_SPART, T_NONE} tgt_e;

  // Map a CPU data address onto exactly one target.
  function automatic tgt_e decode(input logic [15:0] a);
    if (a <= MEM_TOP)                     return T_MEM;
    if (a == LED_ADDR)                    return T_LED;
    if (a == SW_ADDR)                     return T_SW;
    if (a[15:2] == SPART_BASE[15:2])      return T_SPART;
    return T_NONE;
  endfunction

endpackage

// File: rtl/mmio_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous level inputs (slide switches).
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d, sync_q, sync_d;

  // Shift the raw input through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: routes CPU loads/stores to data memory, LEDs, switches
// or the SPART, sequencing SPART accesses and stalling the CPU on queue
// back-pressure with a bounded wait.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LED_W          = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic [15:0]      rdata,
  output logic             stall,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [15:0]      mem_rdata,
  output logic             iocs_n,
  output logic             iorw_n,
  output logic [1:0]       ioaddr,
  output logic [7:0]       io_wdata,
  input  logic [7:0]       io_rdata,
  input  logic             tx_q_full,
  input  logic             rx_q_empty,
  input  logic [LED_W-1:0] SW,
  output logic [LED_W-1:0] LEDR,
  output logic             bus_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             mem_sel_q, mem_sel_d;
  logic [LED_W-1:0] ledr_q, ledr_d, sw_sync;
  logic             iocs_n_q, iocs_n_d, iorw_n_q, iorw_n_d;
  logic [1:0]       ioaddr_q, ioaddr_d;
  logic [7:0]       io_wdata_q, io_wdata_d;
  logic             bus_err_q, bus_err_d;
  logic             enter_strobe;

  tgt_e tgt;
  logic ld, st, both, idle, spart_req, blocked;
  logic unused;

  sync2 #(.W(LED_W)) u_sw_sync (.clk(clk), .rst_n(rst_n), .d(SW), .q(sw_sync));

  assign tgt       = decode(addr);
  assign ld        = re & ~we;
  assign st        = we & ~re;
  assign both      = we & re;
  assign idle      = (state_q == IDLE);
  assign spart_req = idle & (tgt == T_SPART) & (ld | st);
  // Only the data register waits on queue state; status/DB never block.
  assign blocked   = (addr[1:0] == 2'b00) & ((st & tx_q_full) | (ld & rx_q_empty));

  // Memory strobes pass straight through; outside IDLE the held address
  // belongs to an in-flight SPART access.
  assign mem_we = rst_n & idle & (tgt == T_MEM) & st;
  assign mem_re = rst_n & idle & (tgt == T_MEM) & ld;
  assign stall  = rst_n & (spart_req | (state_q == WAIT) | (state_q == STROBE));

  assign rdata    = mem_sel_q ? mem_rdata : rdata_q;
  assign LEDR     = ledr_q;
  assign iocs_n   = iocs_n_q;
  assign iorw_n   = iorw_n_q;
  assign ioaddr   = ioaddr_q;
  assign io_wdata = io_wdata_q;
  assign bus_err  = bus_err_q;
  assign unused   = ^wdata;

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = mem_sel_q ? mem_rdata : rdata_q;
    mem_sel_d    = 1'b0;
    ledr_d       = ledr_q;
    iocs_n_d     = 1'b1;
    iorw_n_d     = 1'b1;
    ioaddr_d     = ioaddr_q;
    io_wdata_d   = io_wdata_q;
    bus_err_d    = 1'b0;
    enter_strobe = 1'b0;
    case (state_q)
      IDLE: begin
        if (both) begin
          bus_err_d = 1'b1;
        end else if (ld | st) begin
          case (tgt)
            T_MEM: mem_sel_d = ld;
            T_LED: begin
              if (st) ledr_d = wdata[LED_W-1:0];
              else    rdata_d = 16'(ledr_q);
            end
            T_SW: if (ld) rdata_d = 16'(sw_sync);
            T_SPART: begin
              cnt_d = '0;
              if (blocked) begin
                state_d = WAIT;
              end else begin
                state_d      = STROBE;
                enter_strobe = 1'b1;
              end
            end
            default: begin
              bus_err_d = 1'b1;
              if (ld) rdata_d = 16'h0000;
            end
          endcase
        end
      end
      WAIT: begin
        if (!blocked) begin
          state_d      = STROBE;
          enter_strobe = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
          if (ld) rdata_d = 16'hFFFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STROBE: begin
        state_d = DONE;
        if (ld) rdata_d = {8'h00, io_rdata};
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The chip select is registered, so it is armed on the way into STROBE.
    if (enter_strobe) begin
      iocs_n_d   = 1'b0;
      iorw_n_d   = re;
      ioaddr_d   = addr[1:0];
      io_wdata_d = wdata[7:0];
    end
  end

  // All controller state in one register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      mem_sel_q  <= 1'b0;
      ledr_q     <= '0;
      iocs_n_q   <= 1'b1;
      iorw_n_q   <= 1'b1;
      ioaddr_q   <= '0;
      io_wdata_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      mem_sel_q  <= mem_sel_d;
      ledr_q     <= ledr_d;
      iocs_n_q   <= iocs_n_d;
      iorw_n_q   <= iorw_n_d;
      ioaddr_q   <= ioaddr_d;
      io_wdata_q <= io_wdata_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule
